// File: rtl/mem_stage.sv
// Memory-access stage: waits for data-RAM responses and extends load data.
// Stale responses left outstanding by a flush are counted and dropped.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        ex_to_mem_valid,
    output logic        mem_allowin,
    input  logic [31:0] ex_pc,
    input  logic        ex_res_from_mem,
    input  logic        ex_rf_we,
    input  logic [4:0]  ex_rf_waddr,
    input  logic [31:0] ex_result,
    input  logic        ex_ld_b,
    input  logic        ex_ld_h,
    input  logic        ex_ld_u,
    input  logic        ex_mem_req,
    input  logic        ex_excep_en,
    input  logic        ex_ertn_flush,
    input  logic        ex_srch_conflict,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [31:0] mem_pc,
    output logic        mem_rf_we,
    output logic [4:0]  mem_rf_waddr,
    output logic [31:0] mem_rf_wdata,
    output logic        mem_excep_en,
    output logic        mem_ertn_flush,
    output logic        mem_fwd_we,
    output logic        mem_fwd_block,
    output logic [2:0]  mem_to_ex_bus
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic        r_res_from_mem;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_result;
    logic        r_ld_b;
    logic        r_ld_h;
    logic        r_ld_u;
    logic        r_req;
    logic        r_excep;
    logic        r_ertn;
    logic        r_srch;
    logic        r_resp_got;
    logic [31:0] r_rdata_buf;
    logic [1:0]  r_discard_cnt;

    logic        w_take;
    logic        w_drop;
    logic        w_ready_go;
    logic        w_load;
    logic        w_inc;
    logic [31:0] w_raw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld;

    assign w_take     = data_sram_data_ok & (r_discard_cnt == 2'd0);
    assign w_drop     = data_sram_data_ok & (r_discard_cnt != 2'd0);
    assign w_ready_go = ~r_req | r_resp_got | w_take;
    assign mem_allowin = ~r_valid | (w_ready_go & wb_allowin);
    assign w_load     = ex_to_mem_valid & mem_allowin;
    // a response arriving in the flush cycle is consumed, so nothing to drop
    assign w_inc      = flush & r_valid & r_req & ~r_resp_got & ~w_take;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid        <= 1'b0;
            r_pc           <= 32'h0;
            r_res_from_mem <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= 5'h0;
            r_result       <= 32'h0;
            r_ld_b         <= 1'b0;
            r_ld_h         <= 1'b0;
            r_ld_u         <= 1'b0;
            r_req          <= 1'b0;
            r_excep        <= 1'b0;
            r_ertn         <= 1'b0;
            r_srch         <= 1'b0;
        end else begin
            if (flush)
                r_valid <= 1'b0;
            else if (mem_allowin)
                r_valid <= ex_to_mem_valid;
            if (w_load) begin
                r_pc           <= ex_pc;
                r_res_from_mem <= ex_res_from_mem;
                r_rf_we        <= ex_rf_we;
                r_rf_waddr     <= ex_rf_waddr;
                r_result       <= ex_result;
                r_ld_b         <= ex_ld_b;
                r_ld_h         <= ex_ld_h;
                r_ld_u         <= ex_ld_u;
                r_req          <= ex_mem_req;
                r_excep        <= ex_excep_en;
                r_ertn         <= ex_ertn_flush;
                r_srch         <= ex_srch_conflict;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_resp_got  <= 1'b0;
            r_rdata_buf <= 32'h0;
        end else if (flush || w_load) begin
            r_resp_got <= 1'b0;
        end else if (w_take && r_valid && r_req) begin
            r_resp_got  <= 1'b1;
            r_rdata_buf <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            r_discard_cnt <= 2'd0;
        else if (w_inc && !w_drop && r_discard_cnt != 2'd3)
            r_discard_cnt <= r_discard_cnt + 2'd1;
        else if (w_drop && !w_inc)
            r_discard_cnt <= r_discard_cnt - 2'd1;
    end

    always_comb begin
        w_raw  = r_resp_got ? r_rdata_buf : data_sram_rdata;
        w_byte = 8'h0;
        w_ld   = w_raw;
        case (r_result[1:0])
            2'd0: w_byte = w_raw[7:0];
            2'd1: w_byte = w_raw[15:8];
            2'd2: w_byte = w_raw[23:16];
            2'd3: w_byte = w_raw[31:24];
            default: w_byte = 8'h0;
        endcase
        w_half = r_result[1] ? w_raw[31:16] : w_raw[15:0];
        unique case (1'b1)
            r_ld_b:  w_ld = {{24{~r_ld_u & w_byte[7]}}, w_byte};
            r_ld_h:  w_ld = {{16{~r_ld_u & w_half[15]}}, w_half};
            default: w_ld = w_raw;
        endcase
    end

    assign mem_to_wb_valid = r_valid & w_ready_go;
    assign mem_pc          = r_pc;
    assign mem_rf_we       = r_valid & r_rf_we & ~r_excep;
    assign mem_rf_waddr    = r_rf_waddr;
    assign mem_rf_wdata    = r_res_from_mem ? w_ld : r_result;
    assign mem_excep_en    = r_excep;
    assign mem_ertn_flush  = r_ertn;
    assign mem_fwd_we      = r_valid & r_rf_we;
    assign mem_fwd_block   = r_valid & r_res_from_mem & ~w_ready_go;
    assign mem_to_ex_bus   = {r_valid & r_excep, r_valid & r_ertn,
                              r_valid & r_srch};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, backpressure,
// flush discard, exceptions and reset in the middle of a stall.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        ex_to_mem_valid;
    logic        mem_allowin;
    logic [31:0] ex_pc;
    logic        ex_res_from_mem;
    logic        ex_rf_we;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] ex_result;
    logic        ex_ld_b;
    logic        ex_ld_h;
    logic        ex_ld_u;
    logic        ex_mem_req;
    logic        ex_excep_en;
    logic        ex_ertn_flush;
    logic        ex_srch_conflict;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [31:0] mem_pc;
    logic        mem_rf_we;
    logic [4:0]  mem_rf_waddr;
    logic [31:0] mem_rf_wdata;
    logic        mem_excep_en;
    logic        mem_ertn_flush;
    logic        mem_fwd_we;
    logic        mem_fwd_block;
    logic [2:0]  mem_to_ex_bus;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
        .ex_pc(ex_pc), .ex_res_from_mem(ex_res_from_mem),
        .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_result(ex_result), .ex_ld_b(ex_ld_b), .ex_ld_h(ex_ld_h),
        .ex_ld_u(ex_ld_u), .ex_mem_req(ex_mem_req),
        .ex_excep_en(ex_excep_en), .ex_ertn_flush(ex_ertn_flush),
        .ex_srch_conflict(ex_srch_conflict),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .wb_allowin(wb_allowin),
        .mem_to_wb_valid(mem_to_wb_valid), .mem_pc(mem_pc),
        .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
        .mem_rf_wdata(mem_rf_wdata), .mem_excep_en(mem_excep_en),
        .mem_ertn_flush(mem_ertn_flush), .mem_fwd_we(mem_fwd_we),
        .mem_fwd_block(mem_fwd_block), .mem_to_ex_bus(mem_to_ex_bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clr_ex();
        ex_to_mem_valid  = 1'b0;
        ex_pc            = 32'h0;
        ex_res_from_mem  = 1'b0;
        ex_rf_we         = 1'b0;
        ex_rf_waddr      = 5'h0;
        ex_result        = 32'h0;
        ex_ld_b          = 1'b0;
        ex_ld_h          = 1'b0;
        ex_ld_u          = 1'b0;
        ex_mem_req       = 1'b0;
        ex_excep_en      = 1'b0;
        ex_ertn_flush    = 1'b0;
        ex_srch_conflict = 1'b0;
    endtask

    task automatic send_ld(input logic [31:0] pc, input logic [31:0] addr,
                           input logic b, input logic h, input logic u,
                           input logic [4:0] rd);
        clr_ex();
        ex_to_mem_valid = 1'b1;
        ex_pc           = pc;
        ex_res_from_mem = 1'b1;
        ex_rf_we        = 1'b1;
        ex_rf_waddr     = rd;
        ex_result       = addr;
        ex_ld_b         = b;
        ex_ld_h         = h;
        ex_ld_u         = u;
        ex_mem_req      = 1'b1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_v"}, {31'h0, mem_to_wb_valid}, 32'h0);
        chk({tag, "_pc"}, mem_pc, 32'h0);
        chk({tag, "_wd"}, mem_rf_wdata, 32'h0);
        chk({tag, "_misc"},
            {20'h0, mem_rf_we, mem_rf_waddr, mem_excep_en, mem_ertn_flush,
             mem_fwd_we, mem_fwd_block, mem_to_ex_bus},
            32'h0);
        chk({tag, "_allowin"}, {31'h0, mem_allowin}, 32'h1);
    endtask

    initial begin
        resetn = 1'b0;
        flush = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        wb_allowin = 1'b1;
        clr_ex();
        nxt();
        nxt();
        mid();
        all_zero("rst");
        chk("rst_dcnt", {30'h0, dut.r_discard_cnt}, 32'h0);
        nxt();
        resetn = 1'b1;

        // ALU op
        clr_ex();
        ex_to_mem_valid = 1'b1;
        ex_pc = 32'h1c00_0000;
        ex_result = 32'h1234_5678;
        ex_rf_we = 1'b1;
        ex_rf_waddr = 5'd5;
        nxt();
        clr_ex();
        mid();
        chk("alu_v", {31'h0, mem_to_wb_valid}, 32'h1);
        chk("alu_wd", mem_rf_wdata, 32'h1234_5678);
        chk("alu_wa", {27'h0, mem_rf_waddr}, 32'd5);
        chk("alu_pc", mem_pc, 32'h1c00_0000);
        chk("alu_we", {30'h0, mem_rf_we, mem_fwd_we}, 32'h3);
        chk("alu_blk", {31'h0, mem_fwd_block}, 32'h0);
        nxt();

        // ld.b at ...3, response two cycles later
        send_ld(32'h1c00_0004, 32'h0000_1003, 1'b1, 1'b0, 1'b0, 5'd7);
        nxt();
        clr_ex();
        mid();
        chk("ldb_stall1", {29'h0, mem_to_wb_valid, mem_fwd_block,
                           mem_allowin}, 32'b010);
        nxt();
        mid();
        chk("ldb_stall2", {29'h0, mem_to_wb_valid, mem_fwd_block,
                           mem_allowin}, 32'b010);
        nxt();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80AA_BBCC;
        mid();
        chk("ldb_v", {30'h0, mem_to_wb_valid, mem_fwd_block}, 32'b10);
        chk("ldb_wd", mem_rf_wdata, 32'hFFFF_FF80);
        nxt();
        data_sram_data_ok = 1'b0;

        // ld.bu at ...3, response in the first cycle
        send_ld(32'h1c00_0008, 32'h0000_1003, 1'b1, 1'b0, 1'b1, 5'd8);
        nxt();
        clr_ex();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80AA_BBCC;
        mid();
        chk("ldbu_v", {31'h0, mem_to_wb_valid}, 32'h1);
        chk("ldbu_wd", mem_rf_wdata, 32'h0000_0080);
        nxt();
        data_sram_data_ok = 1'b0;

        // ld.h at ...2 with writeback stalled for 3 cycles
        send_ld(32'h1c00_000c, 32'h0000_2002, 1'b0, 1'b1, 1'b0, 5'd9);
        nxt();
        clr_ex();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h7FFF_0001;
        wb_allowin = 1'b0;
        mid();
        chk("ldh_v0", {30'h0, mem_to_wb_valid, mem_allowin}, 32'b10);
        chk("ldh_wd0", mem_rf_wdata, 32'h0000_7FFF);
        nxt();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'hFFFF_FFFF;
        mid();
        chk("ldh_v1", {30'h0, mem_to_wb_valid, mem_allowin}, 32'b10);
        chk("ldh_wd1", mem_rf_wdata, 32'h0000_7FFF);
        nxt();
        mid();
        chk("ldh_wd2", mem_rf_wdata, 32'h0000_7FFF);
        nxt();
        wb_allowin = 1'b1;
        mid();
        chk("ldh_v3", {30'h0, mem_to_wb_valid, mem_allowin}, 32'b11);
        chk("ldh_wd3", mem_rf_wdata, 32'h0000_7FFF);
        nxt();
        mid();
        chk("ldh_once", {31'h0, mem_to_wb_valid}, 32'h0);

        // flush with an outstanding load, then stale response dropped
        nxt();
        send_ld(32'h1c00_0010, 32'h0000_3000, 1'b0, 1'b0, 1'b0, 5'd10);
        nxt();
        clr_ex();
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        mid();
        chk("fl_v", {30'h0, mem_to_wb_valid, mem_allowin}, 32'b01);
        chk("fl_dcnt", {30'h0, dut.r_discard_cnt}, 32'd1);
        nxt();
        send_ld(32'h1c00_0014, 32'h0000_3004, 1'b0, 1'b0, 1'b0, 5'd11);
        nxt();
        clr_ex();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h0000_DEAD;
        mid();
        chk("fl_stale", {30'h0, mem_to_wb_valid, mem_fwd_block}, 32'b01);
        nxt();
        data_sram_data_ok = 1'b0;
        mid();
        chk("fl_dcnt0", {30'h0, dut.r_discard_cnt}, 32'd0);
        chk("fl_wait", {31'h0, mem_to_wb_valid}, 32'h0);
        nxt();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h0000_0042;
        mid();
        chk("fl_v2", {31'h0, mem_to_wb_valid}, 32'h1);
        chk("fl_wd", mem_rf_wdata, 32'h0000_0042);
        nxt();
        data_sram_data_ok = 1'b0;

        // exception carried from upstream
        clr_ex();
        ex_to_mem_valid = 1'b1;
        ex_pc = 32'h1c00_0018;
        ex_res_from_mem = 1'b1;
        ex_rf_we = 1'b1;
        ex_rf_waddr = 5'd12;
        ex_excep_en = 1'b1;
        ex_srch_conflict = 1'b1;
        nxt();
        clr_ex();
        mid();
        chk("exc_v", {31'h0, mem_to_wb_valid}, 32'h1);
        chk("exc_bus", {29'h0, mem_to_ex_bus}, 32'b101);
        chk("exc_we", {29'h0, mem_rf_we, mem_excep_en, mem_fwd_block},
            32'b010);
        nxt();

        // two flushes with loads outstanding, then reset mid-stall
        send_ld(32'h1c00_0020, 32'h0000_4000, 1'b0, 1'b0, 1'b0, 5'd13);
        nxt();
        clr_ex();
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        send_ld(32'h1c00_0024, 32'h0000_4004, 1'b0, 1'b0, 1'b0, 5'd14);
        nxt();
        clr_ex();
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        send_ld(32'h1c00_0028, 32'h0000_4008, 1'b0, 1'b0, 1'b0, 5'd15);
        nxt();
        clr_ex();
        mid();
        chk("rs_dcnt2", {30'h0, dut.r_discard_cnt}, 32'd2);
        chk("rs_stall", {29'h0, mem_to_wb_valid, mem_fwd_block,
                         mem_allowin}, 32'b010);
        nxt();
        resetn = 1'b0;
        nxt();
        resetn = 1'b1;
        mid();
        all_zero("rs");
        chk("rs_dcnt", {30'h0, dut.r_discard_cnt}, 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
